// File: rtl/interval_timer_if.sv
// Peripheral-bus bundle for the interval timer: word-addressed register access
// plus the level interrupt line back to the CPU.
interface interval_timer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/interval_timer.sv
// Memory-mapped down-counting interval timer with prescaler, one-shot/periodic
// modes and a sticky, maskable level interrupt.
module interval_timer #(
    parameter int unsigned DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    interval_timer_if.slave   bus
);

    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_ctrl;
    logic [3:0]    w_ctrl_nxt;
    logic [31:0]   r_preset;
    logic [31:0]   w_preset_nxt;
    logic [31:0]   r_count;
    logic [31:0]   w_count_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_irq_flag;
    logic          w_irq_flag_nxt;

    logic          w_wr_ctrl;
    logic          w_wr_preset;
    logic          w_en;
    logic          w_tick;
    logic          w_periodic;
    logic [31:0]   w_rdata;

    assign w_wr_ctrl   = bus.we && (bus.addr == 2'd0);
    assign w_wr_preset = bus.we && (bus.addr == 2'd1);
    // EN as it will stand after this edge, so a write launches or stops the FSM immediately
    assign w_en        = w_wr_ctrl ? bus.wdata[0] : r_ctrl[0];
    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_periodic  = (r_ctrl[2:1] == 2'b01);

    always_comb begin
        w_state_nxt    = r_state;
        w_ctrl_nxt     = w_wr_ctrl ? bus.wdata[3:0] : r_ctrl;
        w_preset_nxt   = w_wr_preset ? bus.wdata : r_preset;
        w_count_nxt    = r_count;
        w_presc_nxt    = r_presc;
        w_irq_flag_nxt = r_irq_flag & ~(w_wr_ctrl | w_wr_preset);

        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_presc_nxt = '0;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (r_count > 32'd1) begin
                        w_count_nxt = r_count - 32'd1;
                    end else begin
                        // Entering INT outranks a same-edge clearing write
                        w_count_nxt    = 32'd0;
                        w_state_nxt    = S_INT;
                        w_irq_flag_nxt = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            S_INT: begin
                if (w_periodic) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                    if (!w_wr_ctrl) begin
                        w_ctrl_nxt[0] = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_presc    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_presc    <= w_presc_nxt;
            r_irq_flag <= w_irq_flag_nxt;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.addr)
            2'd0:    w_rdata = {28'd0, r_ctrl};
            2'd1:    w_rdata = r_preset;
            2'd2:    w_rdata = r_count;
            default: w_rdata = 32'd0;
        endcase
    end

    assign bus.rdata = w_rdata;
    // Masking gates only the output; the flag itself stays pending
    assign bus.irq   = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer: one DIV=1 instance for the
// functional scenarios and one DIV=4 instance for the prescaler.
module tb_interval_timer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    interval_timer_if bus1 ();
    interval_timer_if bus4 ();

    interval_timer #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    interval_timer #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // All tasks start and end just after a falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr1(input logic [1:0] a, input logic [31:0] d);
        bus1.addr  = a;
        bus1.wdata = d;
        bus1.we    = 1'b1;
        @(posedge clk);
        #1;
        bus1.we    = 1'b0;
        bus1.wdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic wr4(input logic [1:0] a, input logic [31:0] d);
        bus4.addr  = a;
        bus4.wdata = d;
        bus4.we    = 1'b1;
        @(posedge clk);
        #1;
        bus4.we    = 1'b0;
        bus4.wdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic rd1(input logic [1:0] a, output logic [31:0] d);
        bus1.addr = a;
        #1;
        d = bus1.rdata;
    endtask

    task automatic rd4(input logic [1:0] a, output logic [31:0] d);
        bus4.addr = a;
        #1;
        d = bus4.rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int a = 0; a < 3; a++) begin
            rd1(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_init_reg%0d: got %0h expected 0", a, v);
            end
        end
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_irq: got %b expected 0", bus1.irq);
        end
        rst = 1'b1;
        step(1);
        wr1(2'd1, 32'd10);
        wr1(2'd0, 32'h9);
        step(3);
        rd1(2'd2, v);
        checks++;
        if (v !== 32'd8) begin
            errors++;
            $display("FAIL reset_precount: got %0d expected 8", v);
        end
        #2;
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd1(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_reg%0d: got %0h expected 0", a, v);
            end
        end
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_irq: got %b expected 0", bus1.irq);
        end
        @(negedge clk);
        rst = 1'b1;
        step(4);
        rd1(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle_count: got %0d expected 0", v);
        end
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_irq: got %b expected 0", bus1.irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        wr1(2'd1, 32'd5);
        wr1(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            rd1(2'd2, v);
            checks++;
            if (v !== 32'(6 - k)) begin
                errors++;
                $display("FAIL oneshot_count_e%0d: got %0d expected %0d", k, v, 6 - k);
            end
            checks++;
            if (bus1.irq !== (k == 6)) begin
                errors++;
                $display("FAIL oneshot_irq_e%0d: got %b expected %b", k, bus1.irq, (k == 6));
            end
        end
        step(1);
        rd1(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl: got %0h expected 8", v);
        end
        step(3);
        checks++;
        if (bus1.irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_sticky: got %b expected 1", bus1.irq);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        wr1(2'd1, 32'd3);
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL periodic_preset_clear: got %b expected 0", bus1.irq);
        end
        wr1(2'd0, 32'hB);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            checks++;
            if (bus1.irq !== (k == 4)) begin
                errors++;
                $display("FAIL periodic_first_e%0d: got %b expected %b", k, bus1.irq, (k == 4));
            end
        end
        for (int r = 0; r < 2; r++) begin
            wr1(2'd0, 32'hB);
            checks++;
            if (bus1.irq !== 1'b0) begin
                errors++;
                $display("FAIL periodic_clear_r%0d: got %b expected 0", r, bus1.irq);
            end
            for (int k = 1; k <= 4; k++) begin
                step(1);
                checks++;
                if (bus1.irq !== (k == 4)) begin
                    errors++;
                    $display("FAIL periodic_r%0d_e%0d: got %b expected %b", r, k, bus1.irq, (k == 4));
                end
            end
        end
        wr1(2'd0, 32'h0);
        step(3);
        rd1(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL periodic_stop_ctrl: got %0h expected 0", v);
        end
    endtask

    task automatic test_preset_zero();
        logic [31:0] v;
        wr1(2'd1, 32'd0);
        wr1(2'd0, 32'h9);
        step(1);
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL preset0_e1: got %b expected 0", bus1.irq);
        end
        step(1);
        checks++;
        if (bus1.irq !== 1'b1) begin
            errors++;
            $display("FAIL preset0_e2: got %b expected 1", bus1.irq);
        end
        step(1);
        rd1(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL preset0_ctrl: got %0h expected 8", v);
        end
    endtask

    task automatic test_mask();
        logic [31:0] v;
        wr1(2'd1, 32'd2);
        wr1(2'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            checks++;
            if (bus1.irq !== 1'b0) begin
                errors++;
                $display("FAIL mask_irq_e%0d: got %b expected 0", k, bus1.irq);
            end
        end
        rd1(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mask_ctrl_autoclr: got %0h expected 0", v);
        end
        wr1(2'd0, 32'h8);
        step(2);
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_unmask_cleared: got %b expected 0", bus1.irq);
        end
    endtask

    task automatic test_stop_collide();
        logic [31:0] v;
        wr1(2'd1, 32'd10);
        wr1(2'd0, 32'h9);
        v = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && v != 32'd4; i++) begin
            step(1);
            rd1(2'd2, v);
        end
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL stop_poll: got %0d expected 4", v);
        end
        wr1(2'd0, 32'h8);
        step(3);
        wr1(2'd2, 32'h55);
        wr1(2'd3, 32'hFF);
        rd1(2'd2, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL stop_hold: got %0d expected 4", v);
        end
        rd1(2'd3, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL reserved_read: got %0h expected 0", v);
        end
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL stop_irq: got %b expected 0", bus1.irq);
        end
        wr1(2'd1, 32'd2);
        wr1(2'd0, 32'h9);
        step(1);
        rd1(2'd2, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL restart_reload: got %0d expected 2", v);
        end
        step(2);
        checks++;
        if (bus1.irq !== 1'b1) begin
            errors++;
            $display("FAIL restart_irq: got %b expected 1", bus1.irq);
        end
        wr1(2'd0, 32'hD);
        rd1(2'd0, v);
        checks++;
        if (v !== 32'hD) begin
            errors++;
            $display("FAIL collide_ctrl: got %0h expected d", v);
        end
        checks++;
        if (bus1.irq !== 1'b0) begin
            errors++;
            $display("FAIL collide_clear: got %b expected 0", bus1.irq);
        end
        step(4);
        checks++;
        if (bus1.irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_relaunch: got %b expected 1", bus1.irq);
        end
        wr1(2'd0, 32'h0);
        rd1(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL collide_bus_wins: got %0h expected 0", v);
        end
    endtask

    task automatic test_div4();
        logic [31:0] v;
        logic [31:0] exp;
        wr4(2'd1, 32'd2);
        wr4(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp = (k <= 4) ? 32'd2 : ((k <= 8) ? 32'd1 : 32'd0);
            rd4(2'd2, v);
            checks++;
            if (v !== exp) begin
                errors++;
                $display("FAIL div4_count_e%0d: got %0d expected %0d", k, v, exp);
            end
            checks++;
            if (bus4.irq !== (k == 9)) begin
                errors++;
                $display("FAIL div4_irq_e%0d: got %b expected %b", k, bus4.irq, (k == 9));
            end
        end
        step(1);
        rd4(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL div4_ctrl: got %0h expected 8", v);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b0;
        bus1.addr  = 2'd0;
        bus1.we    = 1'b0;
        bus1.wdata = 32'd0;
        bus4.addr  = 2'd0;
        bus4.we    = 1'b0;
        bus4.wdata = 32'd0;
        @(negedge clk);
        step(2);
        test_reset();
        test_one_shot();
        test_periodic();
        test_preset_zero();
        test_mask();
        test_stop_collide();
        test_div4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
